// File: rtl/delta_sigma_decim.sv
// rtl/delta_sigma_decim.sv - Sinc3 CIC decimator turning a 1-bit delta-sigma stream into unsigned samples
module delta_sigma_decim #(
    parameter int NB_BIT     = 32,
    parameter int DECIM_LOG2 = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              trig_i,
    input  logic              bit_i,
    output logic [NB_BIT-1:0] data_o,
    output logic              data_en_o
);

    localparam int ACC_W = 3 * DECIM_LOG2 + 1;
    localparam int OUT_W = 3 * DECIM_LOG2;
    localparam int PAD_W = NB_BIT - OUT_W;

    // Full-scale comb result R^3; the only value that does not fit in OUT_W bits
    localparam logic [ACC_W-1:0] FULL_SCALE = {1'b1, {OUT_W{1'b0}}};

    typedef enum logic [1:0] {
        WARM0 = 2'd0,
        WARM1 = 2'd1,
        RUN   = 2'd2
    } warm_state_t;

    warm_state_t state_q;
    warm_state_t state_d;
    logic        run;

    logic [ACC_W-1:0]      i1, i2, i3;
    logic [ACC_W-1:0]      i1_nxt, i2_nxt, i3_nxt;
    logic [ACC_W-1:0]      d1, d2, d3;
    logic [ACC_W-1:0]      c1, c2, c3;
    logic [ACC_W-1:0]      raw;
    logic [OUT_W-1:0]      out_val;
    logic [DECIM_LOG2-1:0] cnt;
    logic                  dec_stb;
    logic                  raw_vld;
    logic                  raw_emit;

    // Integrator cascade: each stage adds the value just produced by the previous one
    always_comb begin
        i1_nxt = i1 + ACC_W'(bit_i);
        i2_nxt = i2 + i1_nxt;
        i3_nxt = i3 + i2_nxt;
    end

    // Comb cascade and full-scale clamp; wrap-around keeps the result exact modulo 2^ACC_W
    always_comb begin
        c1 = i3 - d1;
        c2 = c1 - d2;
        c3 = c2 - d3;
        if (raw == FULL_SCALE) begin
            out_val = {OUT_W{1'b1}};
        end else begin
            out_val = raw[OUT_W-1:0];
        end
    end

    // Integrators and decimation counter advance only on bit strobes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            i1      <= '0;
            i2      <= '0;
            i3      <= '0;
            cnt     <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= trig_i && (cnt == '1);
            if (trig_i) begin
                i1  <= i1_nxt;
                i2  <= i2_nxt;
                i3  <= i3_nxt;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Comb delays and raw result update once per decimation boundary
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            raw      <= '0;
            raw_vld  <= 1'b0;
            raw_emit <= 1'b0;
        end else begin
            raw_vld  <= dec_stb;
            raw_emit <= dec_stb && run;
            if (dec_stb) begin
                d1  <= i3;
                d2  <= c1;
                d3  <= c2;
                raw <= c3;
            end
        end
    end

    // Output register: sample is always refreshed, the pulse only once warmed up
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o    <= '0;
            data_en_o <= 1'b0;
        end else begin
            data_en_o <= raw_emit;
            if (raw_vld) begin
                data_o <= NB_BIT'(out_val) << PAD_W;
            end
        end
    end

    // Warm-up state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= WARM0;
        end else begin
            state_q <= state_d;
        end
    end

    // Warm-up next state: one step per comb update until the filter history is full
    always_comb begin
        state_d = state_q;
        if (dec_stb) begin
            case (state_q)
                WARM0:   state_d = WARM1;
                WARM1:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Warm-up output: the comb result is trusted only from the third boundary on
    always_comb begin
        run = (state_q == RUN);
    end

endmodule

// File: tb/tb_delta_sigma_decim.sv
// tb/tb_delta_sigma_decim.sv - self-checking bench for delta_sigma_decim against a convolution model
module tb_delta_sigma_decim;

    localparam int NB = 16;
    localparam int L  = 4;
    localparam int R  = 16;
    localparam int HL = 3 * R - 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig = 1'b0;
    logic          bit_in = 1'b0;
    logic [NB-1:0] data_o;
    logic          data_en_o;

    delta_sigma_decim #(.NB_BIT(NB), .DECIM_LOG2(L)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .trig_i    (trig),
        .bit_i     (bit_in),
        .data_o    (data_o),
        .data_en_o (data_en_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NB-1:0] d;
        logic          emit;
    } ev_t;

    ev_t           evq[$];
    bit            hist[$];
    int            h[HL];
    int            nstrobe, nframe, edge_cnt;
    logic [NB-1:0] exp_data;
    logic          exp_en;
    int            npass, nchk;
    int            pulses, last_edge, gap;
    logic [NB-1:0] last_pulse;
    logic [16:0]   mod_sum;
    logic [15:0]   mod_acc;

    // Sinc3 output = weighted sum of the last 3R-2 bits, weights = box*box*box
    function automatic logic [NB-1:0] filt();
        int y;
        int idx;
        y = 0;
        for (int k = 0; k < HL; k++) begin
            idx = hist.size() - 1 - k;
            if (idx >= 0 && hist[idx]) y += h[k];
        end
        if (y >= R * R * R) y = R * R * R - 1;
        return NB'(y << (NB - 3 * L));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic step(input logic t, input logic b);
        ev_t e;
        trig   = t;
        bit_in = b;
        @(posedge clk);
        edge_cnt++;
        if (rst_n && t) begin
            hist.push_back(b);
            nstrobe++;
            if (nstrobe % R == 0) begin
                nframe++;
                e.cyc  = edge_cnt + 2;
                e.d    = filt();
                e.emit = (nframe >= 3);
                evq.push_back(e);
            end
        end
        #1;
        exp_en = 1'b0;
        if (evq.size() > 0 && evq[0].cyc == edge_cnt) begin
            e        = evq.pop_front();
            exp_en   = e.emit;
            exp_data = e.d;
        end
        check("data_en_o", 32'(data_en_o), 32'(exp_en));
        check("data_o", 32'(data_o), 32'(exp_data));
        if (data_en_o) begin
            pulses++;
            last_pulse = data_o;
            gap        = edge_cnt - last_edge;
            last_edge  = edge_cnt;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        trig  = 1'b0;
        hist.delete();
        evq.delete();
        nstrobe  = 0;
        nframe   = 0;
        exp_data = '0;
        #1;
        check("rst_data_o", 32'(data_o), 32'h0);
        check("rst_data_en", 32'(data_en_o), 32'h0);
        step(1'b0, 1'b0);
        rst_n      = 1'b1;
        pulses     = 0;
        gap        = 0;
        last_edge  = 0;
        last_pulse = 16'hDEAD;
    endtask

    initial begin
        int box[R];
        int b2[2 * R - 1];
        npass    = 0;
        nchk     = 0;
        edge_cnt = 0;
        for (int k = 0; k < R; k++) box[k] = 1;
        for (int k = 0; k < 2 * R - 1; k++) b2[k] = 0;
        for (int k = 0; k < HL; k++) h[k] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++) b2[a + b] += box[a] * box[b];
        for (int a = 0; a < 2 * R - 1; a++)
            for (int b = 0; b < R; b++) h[a + b] += b2[a] * box[b];

        #2;
        // Constant ones: clamped full scale, pulses only from the third boundary
        apply_reset();
        repeat (96) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        check("ones_pulses", 32'(pulses), 32'd4);
        check("ones_value", 32'(last_pulse), 32'hFFF0);
        check("ones_gap", 32'(gap), 32'd16);

        // Constant zeros
        apply_reset();
        repeat (80) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        check("zeros_pulses", 32'(pulses), 32'd3);
        check("zeros_value", 32'(last_pulse), 32'h0);

        // Density 1/2 and 1/4
        apply_reset();
        for (int i = 0; i < 96; i++) step(1'b1, (i % 2) == 0);
        repeat (4) step(1'b0, 1'b0);
        check("half_value", 32'(last_pulse), 32'h8000);
        apply_reset();
        for (int i = 0; i < 96; i++) step(1'b1, (i % 4) == 0);
        repeat (4) step(1'b0, 1'b0);
        check("quarter_value", 32'(last_pulse), 32'h4000);

        // Strobe every third cycle; bits between strobes are noise
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 1'($urandom));
            step(1'b0, 1'($urandom));
            step(1'b1, (i % 2) == 0);
        end
        repeat (4) step(1'b0, 1'b0);
        check("trig3_pulses", 32'(pulses), 32'd3);
        check("trig3_value", 32'(last_pulse), 32'h8000);
        check("trig3_gap", 32'(gap), 32'd48);

        // Loopback through a first-order delta-sigma modulator
        foreach (hist[i]) hist[i] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            apply_reset();
            mod_acc = '0;
            for (int i = 0; i < 96; i++) begin
                mod_sum = {1'b0, mod_acc} + {1'b0, (v == 0) ? 16'h4000 : 16'hC000};
                mod_acc = mod_sum[15:0];
                step(1'b1, mod_sum[16]);
            end
            repeat (4) step(1'b0, 1'b0);
            check("loop_value", 32'(last_pulse), (v == 0) ? 32'h4000 : 32'hC000);
        end

        // Reset mid-frame of a running stream
        apply_reset();
        repeat (56) step(1'b1, 1'b1);
        check("pre_rst_data_o", 32'(data_o), 32'hFFF0);
        apply_reset();
        repeat (47) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        check("post_rst_47", 32'(pulses), 32'd0);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        check("post_rst_48", 32'(pulses), 32'd1);
        check("post_rst_value", 32'(last_pulse), 32'hFFF0);

        // Random strobes and densities
        apply_reset();
        for (int seg = 0; seg < 10; seg++) begin
            int dens;
            dens = $urandom_range(0, 16);
            repeat (200) step($urandom_range(0, 3) != 0, $urandom_range(0, 15) < dens);
        end
        repeat (4) step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/delta_sigma_decim.md
# delta_sigma_decim

Sinc3 (third-order CIC) decimator that turns the 1-bit stream of a first-order delta-sigma modulator back into NB_BIT-wide unsigned samples. It is the receive-side counterpart of the delta-sigma DAC path. It serves two roles: loopback verification of the modulator, and front-end for external 1-bit delta-sigma ADC streams. A bit density d (fraction of ones) maps to data_o ≈ d·2^NB_BIT, the same scaling the modulator uses on its input.

## Interface
- NB_BIT, 32: output sample width. Constraint: NB_BIT >= 3·DECIM_LOG2.
- DECIM_LOG2, 8: log2 of the decimation ratio R = 2^DECIM_LOG2. Allowed range 2..10.
- clk_i  input  1  single system clock; all logic on its rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- trig_i  input  1  bit strobe; bit_i is consumed only on cycles where trig_i=1.
- bit_i  input  1  delta-sigma bitstream (1 = +full-scale, 0 = zero).
- data_o  output  NB_BIT  decimated sample, unsigned, left-aligned; held between updates.
- data_en_o  output  1  one-cycle pulse marking a new valid data_o.

## Operation
- ACC_W = 3·DECIM_LOG2+1.
- All integrator, comb and delay registers are ACC_W bits wide, unsigned, with two's-complement wrap-around. Wrap is intentional and must not be saturated, because the final comb result is exact modulo 2^ACC_W.
- Integrators, on each trig_i cycle: i1 <= i1 + bit_i; i2 <= i2 + i1_next; i3 <= i3 + i2_next. Each stage uses the value just computed by the previous stage (cascade within one cycle).
- Decimation counter (DECIM_LOG2 bits) increments on each trig_i. When trig_i=1 and the counter equals R-1, it wraps to 0 and sets dec_stb for the next cycle.
- Comb stage, on the dec_stb cycle, all in one cycle:
  - c1 = i3 - d1, c2 = c1 - d2, c3 = c2 - d3.
  - Delays update: d1<=i3, d2<=c1, d3<=c2.
  - raw<=c3.
- Result range is 0..R^3. Clamp: if raw == R^3 then out = R^3-1, else out = raw. out fits in 3·DECIM_LOG2 bits.
- data_o <= {out, (NB_BIT-3·DECIM_LOG2) zeros}.
- Warm-up state machine: WARM0 -> WARM1 -> RUN, advancing on each comb update.
  - data_en_o is suppressed in WARM0 and WARM1.
  - data_o is still updated in those states.
  - The first data_en_o is produced for the 3rd decimation boundary after reset.
- trig_i=0 cycles: no state change except the pipeline registers already in flight (dec_stb, raw, data_o, data_en_o).
- trig_i may be high every cycle. With R >= 4, the comb pipeline can never be re-entered before it completes.

## Timing
- Reset (rst_n_i=0, asynchronous): all of the following clear to 0 immediately:
  - integrators, delays, counter, dec_stb, raw;
  - data_o=0, data_en_o=0;
  - warm-up state = WARM0.
- Reset release is synchronized by the integrating design. The block has no requirement other than being quiescent until the first trig_i.
- Latency: trig_i cycle T carries the R-th bit of a frame.
  - dec_stb is high in T+1.
  - raw is valid in T+2.
  - data_o is updated and data_en_o=1 in T+3 (single cycle).
- A trig_i coincident with dec_stb or a data_o update is integrated normally. It belongs to the next frame.
- Reset asserted mid-frame discards the partial frame and restarts warm-up. No data_en_o is emitted for the aborted frame.
- Counter wrap with trig_i sustained: boundaries every R trig strobes, exactly. No bit is dropped or double-counted.

## Test plan
All scenarios use NB_BIT=16, DECIM_LOG2=4 (R=16, ACC_W=13).
- Constant bit_i=1, trig_i=1 every cycle:
  - no data_en_o after 16 or 32 strobes;
  - first data_en_o 3 cycles after strobe 48, with data_o=0xFFF0 (4096 clamped to 4095);
  - every subsequent pulse also 0xFFF0, spaced 16 cycles apart.
- Constant bit_i=0 -> every data_en_o carries data_o=0x0000, including the first, after 48 strobes.
- Repeating pattern 1,0 (d=0.5) -> after warm-up, data_o=0x8000 on every pulse. Repeating 1,0,0,0 -> data_o=0x4000.
- trig_i asserted every 3rd cycle, pattern 1,0 -> same 0x8000 values. Pulses are 48 clocks apart, and the bit_i values on trig_i=0 cycles are ignored.
- Loopback with the delta-sigma modulator:
  - NB_BIT=16, DECIM_LOG2=4, data_i=0x4000, shared trig_i -> decimator data_o=0x4000 after warm-up.
  - data_i=0xC000 -> data_o=0xC000.
- Assert rst_n_i for 1 cycle at strobe 40 of a running stream:
  - data_o and data_en_o drop to 0 in that same cycle, with no clock edge required;
  - the next data_en_o occurs only after 48 further strobes.
